demux1_2_4_seq: RTL and testbench



---
 rtl/demux1_2_4_seq.sv | 96 +++++++++
 tb/tb_demux1_2_4_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/demux1_2_4_seq.sv
// Registered 1-to-2 word demultiplexer: de-interleaves an A/B stream (auto) or
// routes by an explicit select (manual), with held outputs and one-cycle strobes.
module demux1_2_4_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             auto,
  input  logic             s,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             phase
);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_a_reg, out_a_next;
  logic [WIDTH-1:0] out_b_reg, out_b_next;
  logic             valid_a_reg, valid_a_next;
  logic             valid_b_reg, valid_b_next;
  logic [CNT_W-1:0] pair_cnt_reg, pair_cnt_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= WAIT_A;
      out_a_reg    <= '0;
      out_b_reg    <= '0;
      valid_a_reg  <= 1'b0;
      valid_b_reg  <= 1'b0;
      pair_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      out_a_reg    <= out_a_next;
      out_b_reg    <= out_b_next;
      valid_a_reg  <= valid_a_next;
      valid_b_reg  <= valid_b_next;
      pair_cnt_reg <= pair_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    out_a_next    = out_a_reg;
    out_b_next    = out_b_reg;
    valid_a_next  = 1'b0;
    valid_b_next  = 1'b0;
    pair_cnt_next = pair_cnt_reg;

    if (!auto) begin
      // Parking in WAIT_A makes the first word after a switch to auto land on A.
      state_next = WAIT_A;
      if (din_valid) begin
        if (s) begin
          out_b_next   = din;
          valid_b_next = 1'b1;
        end else begin
          out_a_next   = din;
          valid_a_next = 1'b1;
        end
      end
    end else if (din_valid) begin
      if (sync || state_reg == WAIT_A) begin
        out_a_next   = din;
        valid_a_next = 1'b1;
        state_next   = WAIT_B;
      end else begin
        out_b_next    = din;
        valid_b_next  = 1'b1;
        pair_cnt_next = pair_cnt_reg + 1'b1;
        state_next    = WAIT_A;
      end
    end else if (sync) begin
      // Drop a half-received pair without counting it.
      state_next = WAIT_A;
    end
  end

  assign out_a    = out_a_reg;
  assign out_b    = out_b_reg;
  assign valid_a  = valid_a_reg;
  assign valid_b  = valid_b_reg;
  assign pair_cnt = pair_cnt_reg;
  assign phase    = state_reg;

endmodule

// File: tb/tb_demux1_2_4_seq.sv
// Directed plus randomized checks of demux1_2_4_seq against a pair-tracking
// reference model.
module tb_demux1_2_4_seq;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             auto;
  logic             s;
  logic             sync;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             valid_a;
  logic             valid_b;
  logic [CNT_W-1:0] pair_cnt;
  logic             phase;

  int tests = 0;
  int fails = 0;

  // Reference model: held channel values, pair count, and whether an A word
  // is waiting for its B partner.
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  int               m_cnt;
  bit               m_pending;
  bit               m_va;
  bit               m_vb;

  always #5 clk = ~clk;

  demux1_2_4_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (din),
    .din_valid(din_valid),
    .auto     (auto),
    .s        (s),
    .sync     (sync),
    .out_a    (out_a),
    .out_b    (out_b),
    .valid_a  (valid_a),
    .valid_b  (valid_b),
    .pair_cnt (pair_cnt),
    .phase    (phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rn, input logic [WIDTH-1:0] d, input bit v,
                       input bit au, input bit sel, input bit sy);
    m_va = 1'b0;
    m_vb = 1'b0;
    if (!rn) begin
      m_a = '0; m_b = '0; m_cnt = 0; m_pending = 1'b0;
    end else if (!au) begin
      m_pending = 1'b0;
      if (v && sel) begin m_b = d; m_vb = 1'b1; end
      else if (v)   begin m_a = d; m_va = 1'b1; end
    end else if (v) begin
      if (sy || !m_pending) begin
        m_a = d; m_va = 1'b1; m_pending = 1'b1;
      end else begin
        m_b = d; m_vb = 1'b1; m_cnt = (m_cnt + 1) % 256; m_pending = 1'b0;
      end
    end else if (sy) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic step(input bit rn, input logic [WIDTH-1:0] d, input bit v,
                      input bit au, input bit sel, input bit sy);
    @(negedge clk);
    reset_n = rn; din = d; din_valid = v; auto = au; s = sel; sync = sy;
    @(posedge clk);
    #1;
    model(rn, d, v, au, sel, sy);
    $display("[TB] rn=%0b din=%h v=%0b auto=%0b s=%0b sync=%0b -> a=%h b=%h va=%0b vb=%0b cnt=%0d ph=%0b",
             rn, d, v, au, sel, sy, out_a, out_b, valid_a, valid_b, pair_cnt, phase);
    check("out_a",    32'(out_a),    32'(m_a));
    check("out_b",    32'(out_b),    32'(m_b));
    check("valid_a",  32'(valid_a),  32'(m_va));
    check("valid_b",  32'(valid_b),  32'(m_vb));
    check("pair_cnt", 32'(pair_cnt), 32'(m_cnt));
    check("phase",    32'(phase),    32'(m_pending));
  endtask

  initial begin
    reset_n = 1'b0; din = '0; din_valid = 1'b0; auto = 1'b1; s = 1'b0; sync = 1'b0;
    m_a = '0; m_b = '0; m_cnt = 0; m_pending = 1'b0; m_va = 1'b0; m_vb = 1'b0;

    // Reset overrides a valid word.
    step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    step(1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_a", 32'(out_a), 32'h9);
    check("post_rst_va", 32'(valid_a), 32'd1);

    // Realign, then de-interleave four words.
    step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
    check("auto_a", 32'(out_a), 32'hC);
    check("auto_b", 32'(out_b), 32'h3);
    check("auto_cnt", 32'(pair_cnt), 32'd2);
    check("auto_phase", 32'(phase), 32'd0);

    // Sync mid-pair discards the half pair.
    step(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sync_phase", 32'(phase), 32'd0);
    check("sync_cnt", 32'(pair_cnt), 32'd2);
    step(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sync_a", 32'(out_a), 32'h2);
    check("sync_b", 32'(out_b), 32'h3);

    // Sync with data while in WAIT_B forces A.
    step(1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);
    check("syncd_a", 32'(out_a), 32'h7);
    check("syncd_vb", 32'(valid_b), 32'd0);
    check("syncd_phase", 32'(phase), 32'd1);

    // Manual routing, then idle.
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1);
    check("man_a", 32'(out_a), 32'h0);
    check("man_b", 32'(out_b), 32'hF);
    check("man_cnt", 32'(pair_cnt), 32'd2);
    check("man_phase", 32'(phase), 32'd0);

    // Counter wrap over 256 pairs from a clean reset.
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 254) check("wrap_255", 32'(pair_cnt), 32'd255);
    end
    check("wrap_cnt", 32'(pair_cnt), 32'd0);
    check("wrap_vb", 32'(valid_b), 32'd1);

    // Randomized mix of modes, sync, idle and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
